// File: rtl/tdm_demux_1_4_pkg.sv
// Shared definitions for the 4-slot TDM demultiplexer: framing states,
// channel count and lane-offset helper.
package tdm_demux_1_4_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int NUM_CH = 4;
  localparam int SLOT_W = 2;

  // Bit offset of channel ch inside a packed NUM_CH*width lane vector.
  function automatic int unsigned ch_lo(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/tdm_demux_1_4.sv
// 1:4 time-division demultiplexer. Beats are staged per slot in a shadow
// buffer and published to y_out only when a full, correctly framed set arrives.
module tdm_demux_1_4
  import tdm_demux_1_4_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [WIDTH-1:0]        d_in,
  input  logic                    valid_in,
  input  logic                    sync_in,
  output logic [NUM_CH*WIDTH-1:0] y_out,
  output logic                    frame_valid_out,
  output logic                    lock_out,
  output logic                    err_out
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CH - 1);
  localparam logic [SLOT_W-1:0] ONE       = SLOT_W'(1);

  state_t                    state;
  logic [SLOT_W-1:0]         slot;
  logic [NUM_CH*WIDTH-1:0]   shadow;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= HUNT;
      slot            <= '0;
      shadow          <= '0;
      y_out           <= '0;
      frame_valid_out <= 1'b0;
      lock_out        <= 1'b0;
      err_out         <= 1'b0;
    end else begin
      frame_valid_out <= 1'b0;
      err_out         <= 1'b0;
      if (valid_in) begin
        case (state)
          HUNT: begin
            // Non-sync beats while hunting are silently dropped.
            if (sync_in) begin
              shadow[ch_lo(0, WIDTH) +: WIDTH] <= d_in;
              slot     <= ONE;
              state    <= LOCKED;
              lock_out <= 1'b1;
            end
          end
          LOCKED: begin
            if (sync_in && (slot != '0)) begin
              // Early sync: abandon the partial frame and restart at channel 0.
              err_out <= 1'b1;
              shadow[ch_lo(0, WIDTH) +: WIDTH] <= d_in;
              slot    <= ONE;
            end else if (!sync_in && (slot == '0)) begin
              err_out  <= 1'b1;
              state    <= HUNT;
              lock_out <= 1'b0;
            end else begin
              shadow[ch_lo(32'(slot), WIDTH) +: WIDTH] <= d_in;
              slot <= slot + ONE;
              if (slot == LAST_SLOT) begin
                y_out           <= {d_in, shadow[3*WIDTH-1:0]};
                frame_valid_out <= 1'b1;
              end
            end
          end
          default: begin
            state    <= HUNT;
            lock_out <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_1_4.sv
// Self-checking bench for tdm_demux_1_4: directed scenarios plus randomized
// traffic compared against a frame-assembly reference model.
module tb_tdm_demux_1_4;

  localparam int W = 4;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic [W-1:0]  d_in = '0;
  logic          valid_in = 1'b0;
  logic          sync_in = 1'b0;
  logic [4*W-1:0] y_out;
  logic          frame_valid_out;
  logic          lock_out;
  logic          err_out;

  int checks = 0;
  int passed = 0;

  // Reference model: a frame is a list of beats collected since the last sync.
  logic [W-1:0]   frame_q[$];
  logic           m_lock = 1'b0;
  logic [4*W-1:0] m_y = '0;
  logic           m_fv = 1'b0;
  logic           m_err = 1'b0;

  tdm_demux_1_4 #(.WIDTH(W)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .d_in            (d_in),
    .valid_in        (valid_in),
    .sync_in         (sync_in),
    .y_out           (y_out),
    .frame_valid_out (frame_valid_out),
    .lock_out        (lock_out),
    .err_out         (err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic model_step(input logic r, input logic v, input logic s, input logic [W-1:0] d);
    m_fv  = 1'b0;
    m_err = 1'b0;
    if (r) begin
      m_y    = '0;
      m_lock = 1'b0;
      frame_q.delete();
    end else if (v) begin
      if (!m_lock) begin
        if (s) begin
          m_lock = 1'b1;
          frame_q.delete();
          frame_q.push_back(d);
        end
      end else if (s && frame_q.size() != 0) begin
        m_err = 1'b1;
        frame_q.delete();
        frame_q.push_back(d);
      end else if (!s && frame_q.size() == 0) begin
        m_err  = 1'b1;
        m_lock = 1'b0;
      end else begin
        frame_q.push_back(d);
        if (frame_q.size() == 4) begin
          m_y  = {frame_q[3], frame_q[2], frame_q[1], frame_q[0]};
          m_fv = 1'b1;
          frame_q.delete();
        end
      end
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic s, input logic [W-1:0] d);
    rst_in   = r;
    valid_in = v;
    sync_in  = s;
    d_in     = d;
    @(posedge clk_in);
    model_step(r, v, s, d);
    #1;
    rst_in   = 1'b0;
    valid_in = 1'b0;
    sync_in  = 1'b0;
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 4'hA);
    drive(1, 1, 1, 4'hA);
    checks++; if (y_out !== 16'h0) $display("FAIL reset_y actual=%h required=%h", y_out, 16'h0); else passed++;
    checks++; if (frame_valid_out !== 1'b0) $display("FAIL reset_fv actual=%b required=0", frame_valid_out); else passed++;
    checks++; if (lock_out !== 1'b0) $display("FAIL reset_lock actual=%b required=0", lock_out); else passed++;
    checks++; if (err_out !== 1'b0) $display("FAIL reset_err actual=%b required=0", err_out); else passed++;
  endtask

  task automatic test_clean_frame();
    drive(0, 1, 1, 4'hA);
    checks++; if (lock_out !== 1'b1) $display("FAIL clean_lock actual=%b required=1", lock_out); else passed++;
    checks++; if (frame_valid_out !== 1'b0) $display("FAIL clean_fv_early actual=%b required=0", frame_valid_out); else passed++;
    drive(0, 1, 0, 4'hB);
    drive(0, 1, 0, 4'hC);
    drive(0, 1, 0, 4'hD);
    checks++; if (y_out !== 16'hDCBA) $display("FAIL clean_y actual=%h required=%h", y_out, 16'hDCBA); else passed++;
    checks++; if (frame_valid_out !== 1'b1) $display("FAIL clean_fv actual=%b required=1", frame_valid_out); else passed++;
    drive(0, 0, 0, 4'h0);
    checks++; if (frame_valid_out !== 1'b0) $display("FAIL clean_fv_pulse actual=%b required=0", frame_valid_out); else passed++;
    checks++; if (y_out !== 16'hDCBA) $display("FAIL clean_y_hold actual=%h required=%h", y_out, 16'hDCBA); else passed++;
  endtask

  task automatic test_gapped_frame();
    logic [W-1:0] beats[4];
    beats = '{4'hA, 4'hB, 4'hC, 4'hD};
    drive(1, 0, 0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, (i == 0), beats[i]);
      if (i < 3) begin
        checks++; if (frame_valid_out !== 1'b0) $display("FAIL gap_fv_beat%0d actual=%b required=0", i, frame_valid_out); else passed++;
        for (int g = 0; g < 2; g++) begin
          drive(0, 0, 1, 4'hF);
          checks++; if (frame_valid_out !== 1'b0 || err_out !== 1'b0) $display("FAIL gap_idle%0d actual=fv%b/err%b required=0/0", i, frame_valid_out, err_out); else passed++;
        end
      end
    end
    checks++; if (y_out !== 16'hDCBA) $display("FAIL gap_y actual=%h required=%h", y_out, 16'hDCBA); else passed++;
    checks++; if (frame_valid_out !== 1'b1) $display("FAIL gap_fv actual=%b required=1", frame_valid_out); else passed++;
  endtask

  task automatic test_early_sync();
    drive(0, 1, 1, 4'h1);
    drive(0, 1, 0, 4'h2);
    drive(0, 1, 1, 4'h3);
    checks++; if (err_out !== 1'b1) $display("FAIL early_err actual=%b required=1", err_out); else passed++;
    checks++; if (y_out !== 16'hDCBA) $display("FAIL early_y_hold actual=%h required=%h", y_out, 16'hDCBA); else passed++;
    checks++; if (lock_out !== 1'b1) $display("FAIL early_lock actual=%b required=1", lock_out); else passed++;
    drive(0, 1, 0, 4'h4);
    checks++; if (err_out !== 1'b0) $display("FAIL early_err_pulse actual=%b required=0", err_out); else passed++;
    drive(0, 1, 0, 4'h5);
    drive(0, 1, 0, 4'h6);
    checks++; if (y_out !== 16'h6543) $display("FAIL early_y actual=%h required=%h", y_out, 16'h6543); else passed++;
    checks++; if (frame_valid_out !== 1'b1) $display("FAIL early_fv actual=%b required=1", frame_valid_out); else passed++;
  endtask

  task automatic test_missing_sync();
    drive(0, 1, 0, 4'h7);
    checks++; if (err_out !== 1'b1) $display("FAIL miss_err actual=%b required=1", err_out); else passed++;
    checks++; if (lock_out !== 1'b0) $display("FAIL miss_lock actual=%b required=0", lock_out); else passed++;
    drive(0, 1, 0, 4'h8);
    checks++; if (err_out !== 1'b0 || lock_out !== 1'b0) $display("FAIL miss_ignore actual=err%b/lock%b required=0/0", err_out, lock_out); else passed++;
    drive(0, 1, 0, 4'h9);
    checks++; if (err_out !== 1'b0 || y_out !== 16'h6543) $display("FAIL miss_ignore2 actual=err%b/y%h required=0/6543", err_out, y_out); else passed++;
    drive(0, 1, 1, 4'h1);
    checks++; if (lock_out !== 1'b1) $display("FAIL miss_relock actual=%b required=1", lock_out); else passed++;
    drive(0, 1, 0, 4'h2);
    drive(0, 1, 0, 4'h3);
    drive(0, 1, 0, 4'h4);
    checks++; if (y_out !== 16'h4321 || frame_valid_out !== 1'b1) $display("FAIL miss_recover actual=y%h/fv%b required=4321/1", y_out, frame_valid_out); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    drive(0, 1, 1, 4'h1);
    drive(0, 1, 0, 4'h2);
    drive(1, 0, 0, 4'h0);
    checks++; if (y_out !== 16'h0 || lock_out !== 1'b0) $display("FAIL rstmid_clear actual=y%h/lock%b required=0000/0", y_out, lock_out); else passed++;
    drive(0, 1, 0, 4'h3);
    drive(0, 1, 0, 4'h4);
    checks++; if (y_out !== 16'h0) $display("FAIL rstmid_y actual=%h required=0000", y_out); else passed++;
    checks++; if (frame_valid_out !== 1'b0 || lock_out !== 1'b0 || err_out !== 1'b0) $display("FAIL rstmid_flags actual=fv%b/lock%b/err%b required=0/0/0", frame_valid_out, lock_out, err_out); else passed++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      drive(0, 1, (i % 4 == 0), W'($urandom));
      checks++;
      if (frame_valid_out !== m_fv || y_out !== m_y || err_out !== 1'b0)
        $display("FAIL b2b_cycle%0d actual=y%h/fv%b/err%b required=y%h/fv%b/err0", i, y_out, frame_valid_out, err_out, m_y, m_fv);
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      logic r, v, s;
      r = ($urandom_range(99) < 2);
      v = ($urandom_range(99) < 70);
      // Mostly well-formed framing, with occasional misplaced or missing syncs.
      if (frame_q.size() == 0) s = ($urandom_range(99) < 85);
      else                     s = ($urandom_range(99) < 10);
      drive(r, v, s, W'($urandom));
      checks++;
      if (y_out !== m_y || frame_valid_out !== m_fv || lock_out !== m_lock || err_out !== m_err)
        $display("FAIL rand_cycle%0d actual=y%h/fv%b/lock%b/err%b required=y%h/fv%b/lock%b/err%b",
                 i, y_out, frame_valid_out, lock_out, err_out, m_y, m_fv, m_lock, m_err);
      else passed++;
      if (frame_valid_out && err_out) begin
        checks++;
        $display("FAIL rand_fv_err_overlap actual=11 required=not both");
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_gapped_frame();
    test_early_sync();
    test_missing_sync();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/tdm_demux_1_4.md
# tdm_demux_1_4

Time-division demultiplexer: receives a 4-slot time-multiplexed stream on one narrow bus and distributes the beats to four channel lanes. It is the receiving end of the 4:1 selection datapath. Per-slot beats are staged in a shadow buffer, and the output is updated coherently once per complete frame. A sync marker tracks framing; an error flag reports framing loss.

## Interface
- WIDTH, 4, data width of one slot/channel.
- clk_in  input  1  clock; all logic on rising edge.
- rst_in  input  1  synchronous, active-high reset.
- d_in  input  WIDTH  slot data beat.
- valid_in  input  1  d_in/sync_in qualify this cycle; low = idle gap.
- sync_in  input  1  marks current beat as slot 0 (channel 0); ignored when valid_in low.
- y_out  output  4*WIDTH  last complete frame; channel n at bits [n*WIDTH +: WIDTH].
- frame_valid_out  output  1  one-cycle pulse: y_out just updated with a new frame.
- lock_out  output  1  high while in LOCKED state.
- err_out  output  1  one-cycle pulse on framing error.

## Operation
- State machine: HUNT, LOCKED. A 2-bit slot counter `slot` gives the next expected channel. The shadow buffer holds 4×WIDTH bits.
- Reset:
  - y_out=0, frame_valid_out=0, lock_out=0, err_out=0.
  - shadow=0, slot=0, state=HUNT.
- valid_in low: no state, slot, shadow or output change. frame_valid_out and err_out are 0. Gaps of any length are legal.
- HUNT:
  - valid_in && sync_in: shadow[0]<=d_in, slot<=1, go LOCKED.
  - valid_in && !sync_in: beat discarded, no error.
- LOCKED, valid_in high:
  - Expected beat (sync_in==(slot==0)): shadow[slot]<=d_in, slot<=slot+1 (wraps 3→0).
  - When slot==3: y_out<={d_in, shadow[2], shadow[1], shadow[0]}, frame_valid_out<=1.
  - Early sync (sync_in && slot!=0): err_out<=1. The partial frame is dropped; y_out is unchanged. The beat becomes the new channel 0: shadow[0]<=d_in, slot<=1. Stay LOCKED.
  - Missing sync (!sync_in && slot==0): err_out<=1. The beat is discarded; go HUNT, lock_out<=0.
- frame_valid_out and err_out are never high in the same cycle.
- The shadow is not cleared on errors. Stale lanes never reach y_out, because y_out loads only on a completed slot-3 beat.

## Timing
- All outputs are registered. They change only on a rising edge of clk_in.
- Latency: the fourth beat of a frame is sampled at edge N. y_out and frame_valid_out are visible after edge N; the pulse lasts exactly one cycle.
- lock_out rises after the edge that samples the first sync beat. It falls after the edge that samples a missing-sync beat.
- err_out appears after the edge that samples the offending beat, for one cycle.
- Back-to-back frames with valid_in continuously high sustain one frame per 4 cycles. frame_valid_out then pulses every 4th cycle.
- rst_in has priority over all inputs. Asserting it mid-frame discards the partial frame; the next frame requires a sync beat.

## Structure
- Shared package:
  - State enum {HUNT, LOCKED}.
  - NUM_CH=4 and SLOT_W=2 constants.
  - Channel-slice helper for y_out indexing.
- Single module; no sub-module. The slot counter and shadow buffer are small enough to stay inline.

## Test plan
- Reset: hold rst_in 2 cycles with valid_in=1, sync_in=1 → all outputs 0, lock_out=0, no pulses.
- Clean frame (WIDTH=4): beats 0xA(sync), 0xB, 0xC, 0xD on consecutive cycles → after 4th edge y_out=16'hDCBA and frame_valid_out high 1 cycle; lock_out=1 from the cycle after the first beat.
- Gapped frame: same beats with 2 idle cycles between each → identical y_out=16'hDCBA, single frame_valid_out only after 0xD, no err_out.
- Early sync: after frame 16'hDCBA, send 1(sync), 2, 3(sync), 4, 5, 6 → err_out pulse after beat 3, y_out stays 16'hDCBA, then y_out=16'h6543 with frame_valid_out.
- Missing sync: after a complete frame, send 0x7 without sync → err_out pulse, lock_out=0. Subsequent non-sync beats are ignored with no further err_out. Recovery occurs on the next sync frame.
- Reset mid-frame: send 0x1(sync), 0x2, then rst_in 1 cycle, then 0x3, 0x4 without sync → outputs 0, no frame_valid_out, lock_out stays 0.
